// File: rtl/or4b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : or4b_pkg
// Description : Shared types, sizes and golden model for the four-input OR
//               stimulus/response checker.
// Revision    : 1.0 - initial release
// ============================================================================
package or4b_pkg;

    localparam int NUM_VEC = 16;
    localparam int ERR_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        FIN   = 2'd3
    } state_t;

    // Expected {e,f,g} for a stimulus vector ordered {a,b,c,d}.
    function automatic logic [2:0] golden_efg(input logic [3:0] vec);
        logic w_e;
        logic w_f;
        w_e = vec[3] | vec[2];
        w_f = vec[1] | vec[0];
        return {w_e, w_f, w_e | w_f};
    endfunction

endpackage
`default_nettype wire

// File: rtl/or4b_hold_timer.sv
`default_nettype none
// ============================================================================
// Module      : or4b_hold_timer
// Description : Loadable down-counter with enable and zero flag; times how
//               long each stimulus vector is held.
// Revision    : 1.0 - initial release
// ============================================================================
module or4b_hold_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; the count parks at zero rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/or4b_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : or4b_stim_checker
// Description : Sweeps all 16 {a,b,c,d} combinations into the two-level OR
//               block, samples {e,f,g} after each hold period and records the
//               mismatch count and the first failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module or4b_stim_checker
    import or4b_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [3:0]       first_err_vec
);

    localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]       c_last_idx  = 4'(NUM_VEC - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [3:0]       r_stim;
    logic [ERR_W-1:0] r_err_cnt;
    logic             r_first_valid;
    logic [3:0]       r_first_vec;

    logic             w_sweep_start;
    logic             w_check_fail;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_tmr_zero;

    or4b_hold_timer #(
        .CNT_W (CNT_W)
    ) u_hold_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (c_hold_load),
        .en       (w_tmr_en),
        .zero     (w_tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control; responses are only looked at in CHECK.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_sweep_start = 1'b0;
        w_check_fail  = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_en      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_sweep_start = 1'b1;
                    w_idx_nxt     = 4'd0;
                    w_tmr_load    = 1'b1;
                    w_state_nxt   = DRIVE;
                end
            end
            DRIVE: begin
                if (w_tmr_zero) begin
                    w_state_nxt = CHECK;
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            CHECK: begin
                w_check_fail = ({e, f, g} != golden_efg(r_idx));
                if (r_idx == c_last_idx) begin
                    w_state_nxt = FIN;
                end else begin
                    w_idx_nxt   = r_idx + 4'd1;
                    w_tmr_load  = 1'b1;
                    w_state_nxt = DRIVE;
                end
            end
            FIN: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Vector index, registered stimulus and result bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx         <= 4'd0;
            r_stim        <= 4'd0;
            r_err_cnt     <= '0;
            r_first_valid <= 1'b0;
            r_first_vec   <= 4'd0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_stim <= ((w_state_nxt == DRIVE) || (w_state_nxt == CHECK)) ? w_idx_nxt : 4'd0;
            if (w_sweep_start) begin
                r_err_cnt     <= '0;
                r_first_valid <= 1'b0;
                r_first_vec   <= 4'd0;
            end else if (w_check_fail) begin
                r_err_cnt <= r_err_cnt + ERR_W'(1);
                if (!r_first_valid) begin
                    r_first_valid <= 1'b1;
                    r_first_vec   <= r_idx;
                end
            end
        end
    end

    assign {a, b, c, d}    = r_stim;
    assign busy            = (r_state == DRIVE) || (r_state == CHECK);
    assign done            = (r_state == FIN);
    assign err_cnt         = r_err_cnt;
    assign first_err_valid = r_first_valid;
    assign first_err_vec   = r_first_vec;

endmodule
`default_nettype wire

// File: tb/tb_or4b_stim_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_or4b_stim_checker
// Description : Self-checking bench for or4b_stim_checker with a faultable
//               OR-block responder and a scoreboard of expected sweep results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_or4b_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start;
    logic sel;
    int   fault_mode;

    logic a10, b10, c10, d10, e10, f10, g10, busy10, done10, fv10;
    logic a1,  b1,  c1,  d1,  e1,  f1,  g1,  busy1,  done1,  fv1;
    logic [4:0] err10, err1;
    logic [3:0] fvec10, fvec1;
    logic start10, start1;

    logic [3:0] vec_m;
    logic       busy_m, done_m, fv_m;
    logic [4:0] err_m;
    logic [3:0] fvec_m;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] cnt;
        logic       fv;
        logic [3:0] fvec;
        int         lat;
    } exp_t;
    exp_t sb[$];

    assign start10 = start & ~sel;
    assign start1  = start & sel;
    assign vec_m   = sel ? {a1, b1, c1, d1} : {a10, b10, c10, d10};
    assign busy_m  = sel ? busy1  : busy10;
    assign done_m  = sel ? done1  : done10;
    assign err_m   = sel ? err1   : err10;
    assign fv_m    = sel ? fv1    : fv10;
    assign fvec_m  = sel ? fvec1  : fvec10;

    or4b_stim_checker #(.HOLD_CYCLES(10), .CNT_W(8)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10),
        .a(a10), .b(b10), .c(c10), .d(d10), .e(e10), .f(f10), .g(g10),
        .busy(busy10), .done(done10), .err_cnt(err10),
        .first_err_valid(fv10), .first_err_vec(fvec10)
    );

    or4b_stim_checker #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1),
        .busy(busy1), .done(done1), .err_cnt(err1),
        .first_err_valid(fv1), .first_err_vec(fvec1)
    );

    // OR block under test: 0 = correct, 1 = g stuck at 0, 2 = f follows c only.
    function automatic logic [2:0] respond(input logic [3:0] v, input int mode);
        logic ab;
        logic cd;
        ab = v[3] | v[2];
        cd = v[1] | v[0];
        case (mode)
            1:       return {ab, cd, 1'b0};
            2:       return {ab, v[1], ab | cd};
            default: return {ab, cd, ab | cd};
        endcase
    endfunction

    always_comb begin
        {e10, f10, g10} = respond({a10, b10, c10, d10}, fault_mode);
        {e1, f1, g1}    = respond({a1, b1, c1, d1}, fault_mode);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; raises start immediately and follows the sweep.
    task automatic run_sweep(input bit s, input int hold, input int mode,
                             input logic [4:0] ecnt, input logic efv,
                             input logic [3:0] efvec, input bit inject);
        exp_t item;
        exp_t got;
        int   cycles;
        int   exp_v;
        int   run;
        bit   walk_ok;
        bit   got_done;
        bit   injected;
        sel        = s;
        fault_mode = mode;
        item.cnt   = ecnt;
        item.fv    = efv;
        item.fvec  = efvec;
        item.lat   = 16 * (hold + 1) + 1;
        sb.push_back(item);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        chk("busy_after_start", busy_m, 1'b1);
        chk("err_cleared_at_start", err_m, 5'd0);
        exp_v    = 0;
        run      = 0;
        walk_ok  = 1'b1;
        got_done = 1'b0;
        injected = 1'b0;
        while (cycles <= 400) begin
            start = 1'b0;
            if (busy_m) begin
                if (int'(vec_m) == exp_v) begin
                    run++;
                end else if (int'(vec_m) == exp_v + 1 && run == hold + 1) begin
                    exp_v++;
                    run = 1;
                end else begin
                    walk_ok = 1'b0;
                end
            end
            if (done_m) begin
                got_done = 1'b1;
                break;
            end
            if (inject && !injected && vec_m == 4'd3) begin
                start    = 1'b1;
                injected = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        chk("done_seen", got_done, 1'b1);
        if (got_done) begin
            got = sb.pop_front();
            chk("latency", cycles, got.lat);
            chk("walk", {walk_ok, 8'(exp_v), 8'(run)}, {1'b1, 8'd15, 8'(hold + 1)});
            chk("err_cnt", err_m, got.cnt);
            chk("first_err_valid", fv_m, got.fv);
            chk("first_err_vec", fvec_m, got.fvec);
            chk("fin_stim_zero", vec_m, 4'd0);
            chk("fin_busy_low", busy_m, 1'b0);
            @(negedge clk);
            chk("done_one_cycle", done_m, 1'b0);
            chk("results_held", err_m, got.cnt);
        end
    endtask

    initial begin
        int   wait_cnt;
        bit   saw;
        rst_n      = 1'b0;
        start      = 1'b0;
        sel        = 1'b0;
        fault_mode = 0;
        repeat (3) @(negedge clk);
        chk("rst_stim10", {a10, b10, c10, d10}, 4'd0);
        chk("rst_flags10", {busy10, done10, fv10}, 3'b000);
        chk("rst_err10", err10, 5'd0);
        chk("rst_fvec10", fvec10, 4'd0);
        chk("rst_all1", {a1, b1, c1, d1, busy1, done1, fv1, err1, fvec1}, 18'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(1'b0, 10, 0, 5'd0, 1'b0, 4'd0, 1'b0);
        run_sweep(1'b0, 10, 1, 5'd15, 1'b1, 4'b0001, 1'b0);
        // Back-to-back: start on the cycle right after done, clears err_cnt.
        run_sweep(1'b0, 10, 0, 5'd0, 1'b0, 4'd0, 1'b0);
        // Second start at index 3 must be ignored and not queued.
        run_sweep(1'b0, 10, 2, 5'd4, 1'b1, 4'b0001, 1'b1);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw = saw | busy10 | done10;
        end
        chk("no_queued_start", saw, 1'b0);

        // Reset during vector 7 of a failing sweep.
        sel        = 1'b0;
        fault_mode = 1;
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_cnt = 0;
        while (!({a10, b10, c10, d10} == 4'd7 && busy10) && wait_cnt < 200) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("reached_vec7", wait_cnt < 200, 1'b1);
        chk("err_before_reset", err10, 5'd6);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_stim", {a10, b10, c10, d10}, 4'd0);
        chk("midrst_flags", {busy10, done10, fv10}, 3'b000);
        chk("midrst_results", {err10, fvec10}, 9'd0);
        rst_n = 1'b1;
        saw   = 1'b0;
        repeat (200) begin
            @(negedge clk);
            saw = saw | done10 | busy10;
        end
        chk("no_done_after_abort", saw, 1'b0);
        run_sweep(1'b0, 10, 0, 5'd0, 1'b0, 4'd0, 1'b0);

        // Minimum hold length.
        run_sweep(1'b1, 1, 0, 5'd0, 1'b0, 4'd0, 1'b0);
        run_sweep(1'b1, 1, 2, 5'd4, 1'b1, 4'b0001, 1'b0);
        run_sweep(1'b1, 1, 1, 5'd15, 1'b1, 4'b0001, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/or4b_stim_checker.md
Name: or4b_stim_checker

Overview:
- Upstream stimulus and response-check stage for the two-level four-input OR block (e = a|b, f = c|d, g = e|f).
- On `start`, drives all 16 input combinations onto a,b,c,d in ascending order, with a as MSB and d as LSB.
- Holds each vector for a programmable number of cycles, then samples e,f,g and compares them against the golden values.
- Reports a mismatch count and the first failing vector, so a board or bench run self-checks without waveform inspection.

Parameters:
- HOLD_CYCLES, 10, cycles each vector is held before sampling; legal range 1..255.
- CNT_W, 8, width of the internal hold counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle request to run a full sweep; ignored unless in IDLE.
- a  output  1  stimulus bit 3 (MSB).
- b  output  1  stimulus bit 2.
- c  output  1  stimulus bit 1.
- d  output  1  stimulus bit 0 (LSB).
- e  input  1  DUT response, expected a|b.
- f  input  1  DUT response, expected c|d.
- g  input  1  DUT response, expected a|b|c|d.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- err_cnt  output  5  number of failing vectors in the last sweep, 0..16.
- first_err_valid  output  1  at least one mismatch occurred in the last sweep.
- first_err_vec  output  4  {a,b,c,d} of the first failing vector; valid only when first_err_valid is high.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; a,b,c,d = 0; busy = 0; done = 0.
  - err_cnt = 0; first_err_valid = 0; first_err_vec = 0; vector index = 0; hold counter = 0.
  - Reset mid-sweep aborts immediately: no done pulse, and results are cleared.
- States: IDLE, DRIVE, CHECK, FIN.
- IDLE:
  - Outputs a..d = 0 and busy = 0; results of the previous sweep stay visible.
  - When start = 1: clear err_cnt, first_err_valid and first_err_vec; set vector index = 0 and hold counter = HOLD_CYCLES-1; go to DRIVE.
  - busy rises on the cycle after start.
- DRIVE:
  - {a,b,c,d} = vector index, registered.
  - Hold counter decrements each cycle; when it reaches 0, go to CHECK.
  - Each vector is therefore presented for exactly HOLD_CYCLES cycles in DRIVE plus 1 cycle in CHECK.
- CHECK (one cycle):
  - Compare {e,f,g} with the golden triple computed from the current index.
  - On mismatch: err_cnt += 1. If first_err_valid = 0, also set first_err_valid = 1 and first_err_vec = index.
  - If index = 15, go to FIN. Otherwise index += 1, reload hold counter = HOLD_CYCLES-1, and go to DRIVE.
  - The stimulus updates on the edge leaving CHECK.
- FIN (one cycle):
  - done = 1, busy = 0, a..d = 0; next state is IDLE.
- start asserted outside IDLE (including during FIN) is ignored; it is not queued.
- err_cnt cannot overflow: its maximum is 16 and the register is 5 bits wide.
- Sweep latency from the start edge to the done pulse = 16*(HOLD_CYCLES+1)+1 cycles. For the default HOLD_CYCLES = 10 this is 177.
- e,f,g are sampled only in CHECK. Values on other cycles, including X or glitches, never affect results.
- With HOLD_CYCLES = 1, DRIVE lasts one cycle per vector; the FSM must not skip DRIVE.

Decomposition:
- Package or4b_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK, FIN);
  - NUM_VEC = 16;
  - ERR_W = 5;
  - a function golden_efg(vec[3:0]) returning {a|b, c|d, a|b|c|d}.
- One natural sub-module, or4b_hold_timer: loadable down-counter with load, enable and zero flag, parameterised by CNT_W.
- FSM, vector index and result registers stay in the top module.

Test Plan:
- Correct DUT, HOLD_CYCLES = 10:
  - Pulse start → a..d walk 0000..1111, each held 11 cycles.
  - done pulses 177 cycles after start.
  - err_cnt = 0, first_err_valid = 0.
- g stuck-at-0:
  - err_cnt = 15; first_err_valid = 1; first_err_vec = 4'b0001 (first nonzero vector).
- f tied to c only (d ignored):
  - Failing vectors are 0001, 0101, 1001, 1101 → err_cnt = 4, first_err_vec = 4'b0001.
- rst_n driven low at vector index 7, then released, then start again:
  - Outputs read 0 on the cycle after reset.
  - No done pulse from the aborted run.
  - The fresh sweep completes with correct results.
- Second start pulse at index 3 of a running sweep:
  - Ignored; a single done pulse at the original time.
  - Back-to-back start on the cycle after done launches a new sweep that clears err_cnt.
- HOLD_CYCLES = 1:
  - Each vector is held 2 cycles; done arrives 33 cycles after start; results match the golden function.
